// File: rtl/ase_umsg_engine.sv
// ASE UMsg engine: per-ID hint/data scheduler that turns UMsg cacheline writes into timed RX0 packets.
// Optional statistics counters are built when ASE_UMSG_STATS_EN is defined.
module ase_umsg_engine #(
    parameter int NUM_UMSG_LOG2 = 5,
    parameter int TIMER_W       = 8,
    parameter int HINT_DELAY    = 20,
    parameter int DATA_DELAY    = 40
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       umsg_wr_valid,
    input  logic [NUM_UMSG_LOG2-1:0]   umsg_wr_id,
    input  logic [511:0]               umsg_wr_data,
    input  logic [(1<<NUM_UMSG_LOG2)-1:0] umsg_hint_en,
    input  logic                       rx0_grant,
    output logic                       rx0_valid,
    output logic [27:0]                rx0_hdr,
    output logic [511:0]               rx0_data,
    output logic                       umsg_busy,
    output logic [31:0]                stat_hint_cnt,
    output logic [31:0]                stat_data_cnt
);

    localparam int NUM_UMSG = 1 << NUM_UMSG_LOG2;

    typedef enum logic [2:0] {
        UMSG_IDLE,
        UMSG_CHANGE_OCCURED,
        UMSG_SEND_HINT,
        UMSG_WAITING,
        UMSG_SEND_DATA
    } umsg_state_e;

    umsg_state_e              state_q [NUM_UMSG];
    umsg_state_e              state_d [NUM_UMSG];
    logic [TIMER_W-1:0]       timer_q [NUM_UMSG];
    logic [TIMER_W-1:0]       timer_d [NUM_UMSG];
    logic [511:0]             data_q  [NUM_UMSG];
    logic [NUM_UMSG-1:0]      pending_q;
    logic [NUM_UMSG-1:0]      hint_ready;
    logic [NUM_UMSG-1:0]      data_ready;

    logic [NUM_UMSG_LOG2-1:0] hint_ptr_q;
    logic [NUM_UMSG_LOG2-1:0] data_ptr_q;
    logic [NUM_UMSG_LOG2:0]   hint_pick;
    logic [NUM_UMSG_LOG2:0]   data_pick;
    logic                     pop_hint;
    logic                     pop_data;
    logic [NUM_UMSG_LOG2-1:0] pop_id;
    logic [15:0]              pop_mdata;

    // Round-robin search starting at 'start'; returns {found, id}.
    function automatic logic [NUM_UMSG_LOG2:0] rr_pick(input logic [NUM_UMSG-1:0] req,
                                                       input logic [NUM_UMSG_LOG2-1:0] start);
        logic                     found;
        logic [NUM_UMSG_LOG2-1:0] idx;
        logic [NUM_UMSG_LOG2-1:0] sel;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_UMSG; k++) begin
            idx = start + NUM_UMSG_LOG2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                state_q[i] <= UMSG_IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    // NOTE: defaults first in every combinational block so no path leaves a variable unassigned (no latches).
    always_comb begin
        for (int i = 0; i < NUM_UMSG; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            unique case (state_q[i])
                UMSG_IDLE: begin
                    if (pending_q[i]) state_d[i] = UMSG_CHANGE_OCCURED;
                end
                UMSG_CHANGE_OCCURED: begin
                    state_d[i] = umsg_hint_en[i] ? UMSG_SEND_HINT : UMSG_WAITING;
                    timer_d[i] = '0;
                end
                UMSG_SEND_HINT: begin
                    if (pop_hint && pop_id == NUM_UMSG_LOG2'(i)) begin
                        state_d[i] = UMSG_WAITING;
                        timer_d[i] = '0;
                    end else if (timer_q[i] != TIMER_W'(HINT_DELAY)) begin
                        // Saturates at HINT_DELAY, which is what marks the hint as ready.
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                UMSG_WAITING: begin
                    if (timer_q[i] == TIMER_W'(DATA_DELAY - 1)) state_d[i] = UMSG_SEND_DATA;
                    else                                        timer_d[i] = timer_q[i] + 1'b1;
                end
                UMSG_SEND_DATA: begin
                    if (pop_data && pop_id == NUM_UMSG_LOG2'(i)) state_d[i] = UMSG_IDLE;
                end
                default: begin
                    state_d[i] = UMSG_IDLE;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

    always_comb begin
        hint_ready = '0;
        data_ready = '0;
        umsg_busy  = 1'b0;
        for (int i = 0; i < NUM_UMSG; i++) begin
            hint_ready[i] = (state_q[i] == UMSG_SEND_HINT) && (timer_q[i] == TIMER_W'(HINT_DELAY));
            data_ready[i] = (state_q[i] == UMSG_SEND_DATA);
            if (state_q[i] != UMSG_IDLE) umsg_busy = 1'b1;
        end
    end

    // Hints always win over data; each class keeps its own round-robin pointer.
    always_comb begin
        hint_pick = rr_pick(hint_ready, hint_ptr_q);
        data_pick = rr_pick(data_ready, data_ptr_q);
        pop_hint  = rx0_grant && hint_pick[NUM_UMSG_LOG2];
        pop_data  = rx0_grant && !hint_pick[NUM_UMSG_LOG2] && data_pick[NUM_UMSG_LOG2];
        pop_id    = hint_pick[NUM_UMSG_LOG2] ? hint_pick[NUM_UMSG_LOG2-1:0]
                                             : data_pick[NUM_UMSG_LOG2-1:0];
        pop_mdata = '0;
        pop_mdata[12]                 = pop_hint;
        pop_mdata[NUM_UMSG_LOG2-1:0]  = pop_id;
    end

    // NOTE: the payload store is reset too, so a post-reset UMsg can never expose stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            for (int i = 0; i < NUM_UMSG; i++) data_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                if (umsg_wr_valid && umsg_wr_id == NUM_UMSG_LOG2'(i)) begin
                    data_q[i]    <= umsg_wr_data;
                    pending_q[i] <= 1'b1;
                end else if ((state_q[i] == UMSG_IDLE && pending_q[i]) ||
                             (pop_data && pop_id == NUM_UMSG_LOG2'(i))) begin
                    // A data pop already carries the latest payload, so earlier writes are coalesced.
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx0_valid  <= 1'b0;
            rx0_hdr    <= '0;
            rx0_data   <= '0;
            hint_ptr_q <= '0;
            data_ptr_q <= '0;
        end else begin
            rx0_valid <= pop_hint || pop_data;
            rx0_hdr   <= (pop_hint || pop_data) ? {8'h00, 4'hF, pop_mdata} : 28'h0;
            rx0_data  <= pop_data ? data_q[pop_id] : 512'h0;
            if (pop_hint) hint_ptr_q <= pop_id + 1'b1;
            if (pop_data) data_ptr_q <= pop_id + 1'b1;
        end
    end

`ifdef ASE_UMSG_STATS_EN
    logic [31:0] hint_cnt_q;
    logic [31:0] data_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hint_cnt_q <= '0;
            data_cnt_q <= '0;
        end else begin
            if (pop_hint) hint_cnt_q <= hint_cnt_q + 32'd1;
            if (pop_data) data_cnt_q <= data_cnt_q + 32'd1;
        end
    end

    assign stat_hint_cnt = hint_cnt_q;
    assign stat_data_cnt = data_cnt_q;
`else
    assign stat_hint_cnt = 32'h0;
    assign stat_data_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ase_umsg_engine.sv
// Bench for ase_umsg_engine: timestamp-based reference model checked every cycle, plus directed scenarios.
module tb_ase_umsg_engine;

    localparam int L  = 5;
    localparam int NU = 32;
    localparam int H  = 20;
    localparam int D  = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          umsg_wr_valid = 1'b0;
    logic [L-1:0]  umsg_wr_id = '0;
    logic [511:0]  umsg_wr_data = '0;
    logic [NU-1:0] umsg_hint_en = '0;
    logic          rx0_grant = 1'b0;
    logic          rx0_valid;
    logic [27:0]   rx0_hdr;
    logic [511:0]  rx0_data;
    logic          umsg_busy;
    logic [31:0]   stat_hint_cnt;
    logic [31:0]   stat_data_cnt;

    ase_umsg_engine #(.NUM_UMSG_LOG2(L), .TIMER_W(8), .HINT_DELAY(H), .DATA_DELAY(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .umsg_wr_valid(umsg_wr_valid), .umsg_wr_id(umsg_wr_id), .umsg_wr_data(umsg_wr_data),
        .umsg_hint_en(umsg_hint_en), .rx0_grant(rx0_grant),
        .rx0_valid(rx0_valid), .rx0_hdr(rx0_hdr), .rx0_data(rx0_data),
        .umsg_busy(umsg_busy), .stat_hint_cnt(stat_hint_cnt), .stat_data_cnt(stat_data_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: each ID is idle or waiting for a hint/data slot that opens at a known edge.
    int           mcyc = 0;
    int           m_act  [NU];   // 0 idle, 1 hint outstanding, 2 data outstanding
    int           m_elig [NU];   // first edge at which the outstanding packet may be popped
    bit           m_pend [NU];
    logic [511:0] m_data [NU];
    int           m_hptr = 0, m_dptr = 0;
    int           m_hcnt = 0, m_dcnt = 0;
    logic         exp_valid = 1'b0;
    logic [27:0]  exp_hdr = '0;
    logic [511:0] exp_data = '0;
    logic         exp_busy = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < NU; i++) begin
            m_act[i] = 0; m_elig[i] = 0; m_pend[i] = 1'b0; m_data[i] = '0;
        end
        m_hptr = 0; m_dptr = 0; m_hcnt = 0; m_dcnt = 0;
        exp_valid = 1'b0; exp_hdr = '0; exp_data = '0; exp_busy = 1'b0;
    endtask

    task automatic model_step();
        int  pid;
        bit  ph, pd, wr_hit;
        pid = -1; ph = 1'b0; pd = 1'b0;
        mcyc++;
        if (rx0_grant) begin
            for (int k = 0; k < NU; k++) begin
                int i;
                i = (m_hptr + k) % NU;
                if (pid < 0 && m_act[i] == 1 && mcyc >= m_elig[i]) begin pid = i; ph = 1'b1; end
            end
            if (pid < 0) begin
                for (int k = 0; k < NU; k++) begin
                    int i;
                    i = (m_dptr + k) % NU;
                    if (pid < 0 && m_act[i] == 2 && mcyc >= m_elig[i]) begin pid = i; pd = 1'b1; end
                end
            end
        end
        exp_valid = ph | pd;
        exp_hdr   = (ph | pd) ? (28'h00F0000 | (ph ? 28'h0001000 : 28'h0) | 28'(pid)) : 28'h0;
        exp_data  = pd ? m_data[pid] : 512'h0;
        if (ph) begin
            m_act[pid] = 2; m_elig[pid] = mcyc + D + 1; m_hptr = (pid + 1) % NU; m_hcnt++;
        end
        if (pd) begin
            m_act[pid] = 0; m_pend[pid] = 1'b0; m_dptr = (pid + 1) % NU; m_dcnt++;
        end
        for (int i = 0; i < NU; i++) begin
            if (m_act[i] == 0 && m_pend[i] && !(pd && pid == i)) begin
                m_pend[i] = 1'b0;
                if (umsg_hint_en[i]) begin m_act[i] = 1; m_elig[i] = mcyc + H + 2; end
                else                 begin m_act[i] = 2; m_elig[i] = mcyc + D + 2; end
            end
        end
        wr_hit = umsg_wr_valid;
        if (wr_hit) begin
            m_data[umsg_wr_id] = umsg_wr_data;
            m_pend[umsg_wr_id] = 1'b1;
        end
        exp_busy = 1'b0;
        for (int i = 0; i < NU; i++) if (m_act[i] != 0) exp_busy = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 512'(rx0_valid), 512'(exp_valid));
            check("busy", 512'(umsg_busy), 512'(exp_busy));
            if (exp_valid) begin
                check("hdr", 512'(rx0_hdr), 512'(exp_hdr));
                check("data", rx0_data, exp_data);
            end
`ifdef ASE_UMSG_STATS_EN
            check("stat_hint", 512'(stat_hint_cnt), 512'(m_hcnt));
            check("stat_data", 512'(stat_data_cnt), 512'(m_dcnt));
`else
            check("stat_hint", 512'(stat_hint_cnt), 512'd0);
            check("stat_data", 512'(stat_data_cnt), 512'd0);
`endif
        end
    end

    int w_cyc = 0;

    task automatic do_write(input int id, input logic [511:0] d);
        @(negedge clk);
        umsg_wr_valid = 1'b1; umsg_wr_id = L'(id); umsg_wr_data = d;
        w_cyc = cyc + 1;
        @(negedge clk);
        umsg_wr_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit got, output int at_cyc);
        got = 1'b0; at_cyc = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (rx0_valid) begin got = 1'b1; at_cyc = cyc; end
        end
    endtask

    task automatic rand_line(output logic [511:0] d);
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
    endtask

    task automatic drain(input string name);
        int quiet;
        umsg_wr_valid = 1'b0; rx0_grant = 1'b1; quiet = 0;
        for (int k = 0; k < 400 && quiet < 4; k++) begin
            @(negedge clk);
            quiet = umsg_busy ? 0 : quiet + 1;
        end
        check(name, 512'(quiet >= 4), 512'd1);
    endtask

    initial begin
        bit           got;
        int           at1, at2, cnt;
        logic [511:0] rd, last_d;
        logic [27:0]  hdrs [4];
        int           np;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_valid", 512'(rx0_valid), 512'd0);
        check("reset_hdr", 512'(rx0_hdr), 512'd0);
        check("reset_data", rx0_data, 512'd0);
        check("reset_busy", 512'(umsg_busy), 512'd0);
        #2 rst_n = 1'b1;

        // Unhinted UMsg on ID 3.
        rx0_grant = 1'b1; umsg_hint_en = '0;
        do_write(3, {64{8'hA5}});
        wait_valid(200, got, at1);
        check("s1_seen", 512'(got), 512'd1);
        check("s1_latency", 512'(at1 - w_cyc), 512'd43);
        check("s1_hdr", 512'(rx0_hdr), 512'h00F0003);
        check("s1_data", rx0_data, {64{8'hA5}});
        check("s1_busy", 512'(umsg_busy), 512'd0);
        drain("s1_drain");

        // Hinted UMsg on ID 3.
        umsg_hint_en = 32'h0000_0008;
        do_write(3, {64{8'hA5}});
        wait_valid(200, got, at1);
        check("s2_hint_seen", 512'(got), 512'd1);
        check("s2_hint_latency", 512'(at1 - w_cyc), 512'd23);
        check("s2_hint_hdr", 512'(rx0_hdr), 512'h00F1003);
        check("s2_hint_data", rx0_data, 512'd0);
        wait_valid(200, got, at2);
        check("s2_data_seen", 512'(got), 512'd1);
        check("s2_data_gap", 512'(at2 - at1), 512'd41);
        check("s2_data_hdr", 512'(rx0_hdr), 512'h00F0003);
        check("s2_data", rx0_data, {64{8'hA5}});
        drain("s2_drain");

        // Coalescing on ID 5.
        umsg_hint_en = '0;
        do_write(5, 512'd1);
        repeat (8) @(negedge clk);
        do_write(5, 512'd2);
        do_write(5, 512'd3);
        cnt = 0; last_d = '0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (rx0_valid) begin cnt++; last_d = rx0_data; end
        end
        check("s3_count", 512'(cnt), 512'd1);
        check("s3_data", last_d, 512'd3);
        check("s3_busy", 512'(umsg_busy), 512'd0);

        // Two hinted IDs written back to back: both hints before any data.
        umsg_hint_en = 32'h0000_0081;
        @(negedge clk);
        umsg_wr_valid = 1'b1; umsg_wr_id = 5'd0; umsg_wr_data = 512'h1111;
        @(negedge clk);
        umsg_wr_id = 5'd7; umsg_wr_data = 512'h7777;
        @(negedge clk);
        umsg_wr_valid = 1'b0;
        np = 0;
        for (int k = 0; k < 150 && np < 4; k++) begin
            @(negedge clk);
            if (rx0_valid) begin hdrs[np] = rx0_hdr; np++; end
        end
        check("s4_count", 512'(np), 512'd4);
        if (np == 4) begin
            check("s4_hint0", 512'(hdrs[0]), 512'h00F1000);
            check("s4_hint7", 512'(hdrs[1]), 512'h00F1007);
            check("s4_data0", 512'(hdrs[2]), 512'h00F0000);
            check("s4_data7", 512'(hdrs[3]), 512'h00F0007);
        end
        drain("s4_drain");

        // Grant held low with ID 2 data ready.
        umsg_hint_en = '0; rx0_grant = 1'b0;
        rand_line(rd);
        do_write(2, rd);
        cnt = 0;
        for (int k = 0; k < D + 3 + 200; k++) begin
            @(negedge clk);
            if (rx0_valid) cnt++;
        end
        check("s5_held", 512'(cnt), 512'd0);
        check("s5_busy", 512'(umsg_busy), 512'd1);
        rx0_grant = 1'b1;
        @(negedge clk);
        check("s5_valid", 512'(rx0_valid), 512'd1);
        check("s5_hdr", 512'(rx0_hdr), 512'h00F0002);
        check("s5_data", rx0_data, rd);
        @(negedge clk);
        check("s5_single", 512'(rx0_valid), 512'd0);

        // Reset while ID 4 waits in SendHint.
        umsg_hint_en = 32'h0000_0010;
        rand_line(rd);
        do_write(4, rd);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (rx0_valid) cnt++;
        end
        check("s6_silent", 512'(cnt), 512'd0);
        check("s6_busy", 512'(umsg_busy), 512'd0);
        check("s6_stat_hint", 512'(stat_hint_cnt), 512'd0);
        check("s6_stat_data", 512'(stat_data_cnt), 512'd0);

        // Randomized traffic, checked by the model every cycle.
        for (int ph = 0; ph < 5; ph++) begin
            umsg_hint_en = $urandom();
            for (int k = 0; k < 900; k++) begin
                @(negedge clk);
                umsg_wr_valid = ($urandom_range(0, 3) == 0);
                umsg_wr_id    = ($urandom_range(0, 1) == 1) ? L'($urandom_range(0, 3))
                                                            : L'($urandom_range(0, NU - 1));
                rand_line(rd);
                umsg_wr_data  = rd;
                rx0_grant     = (ph == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            end
            drain("rand_drain");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ase_umsg_engine.md
Name: ase_umsg_engine

Overview:
- Per-UMsg hint/data scheduler for ASE.
- Accepts UMsg cacheline writes from the DPI/SW side and runs one UMsg_StateEnum FSM per UMsg ID (Idle, ChangeOccured, SendHint, Waiting, SendData).
- Emits timed UMsg hint and data packets on the RX0 response path (resptype CCIP_RX0_UMSG = 4'hF).
- Sits directly upstream of the RX0 response mux, which grants it free RX0 slots.

Parameters:
- NUM_UMSG_LOG2, 5, log2 of number of UMsg IDs (NUM_UMSG = 2**NUM_UMSG_LOG2).
- TIMER_W, 8, timer width (matches UMSG_DELAY_TIMER_LOG2).
- HINT_DELAY, 20, cycles from hint timer start to hint_ready; 1..2**TIMER_W-1.
- DATA_DELAY, 40, cycles from data timer start to data_ready; 1..2**TIMER_W-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- umsg_wr_valid  in  1  UMsg write strobe, one per cycle, always accepted.
- umsg_wr_id  in  NUM_UMSG_LOG2  target UMsg ID.
- umsg_wr_data  in  512  cacheline payload (CCIP_DATA_WIDTH).
- umsg_hint_en  in  NUM_UMSG  per-ID hint enable, sampled in ChangeOccured.
- rx0_grant  in  1  RX0 slot free this cycle; engine may pop one packet.
- rx0_valid  out  1  UMsg packet valid.
- rx0_hdr  out  28  RxHdr_t (CCIP_RX_HDR_WIDTH).
- rx0_data  out  512  UMsg data; zero for hints.
- umsg_busy  out  1  OR of (state != UMsg_Idle) over all IDs.
- stat_hint_cnt  out  32  hints sent (feature-gated).
- stat_data_cnt  out  32  data packets sent (feature-gated).

Behaviour:
- Reset (async, rst_n low):
  - All FSMs go to UMsg_Idle; timers, data, data_q and pending flags clear.
  - rx0_valid=0, rx0_hdr=0, rx0_data=0, umsg_busy=0, counters=0.
  - Reset mid-operation discards all in-flight UMsgs; nothing is emitted after release until a new write arrives.
- Write handling: on umsg_wr_valid, data[id] <= umsg_wr_data and pending[id] <= 1 in the same edge.
- Per-ID FSM, one transition per cycle:
  - Idle: if pending, clear pending and go to ChangeOccured.
  - ChangeOccured (1 cycle): if umsg_hint_en[id], go to SendHint with hint_timer=0; else go to Waiting with data_timer=0.
  - SendHint: hint_timer increments to HINT_DELAY-1, then sets hint_ready. On hint pop, go to Waiting with data_timer=0.
  - Waiting: data_timer increments to DATA_DELAY-1, then go to SendData with data_ready=1.
  - SendData: on data pop, data_q <= data[id] and return to Idle. If pending is set, the next cycle goes to ChangeOccured.
  - Timers saturate once ready and do not wrap.
- Coalescing:
  - Writes to a non-Idle ID only update data[id] and set pending.
  - Emitted data is data[id] at pop time, i.e. the latest value.
  - A write in the same cycle as the data pop: the pop carries the old data[id]; the new data is latched and pending=1, producing a new UMsg cycle.
- Arbitration, at most one pop per cycle and only when rx0_grant=1:
  - Any hint_ready has priority over any data_ready.
  - Within a class, round-robin starting at the ID after the last popped ID of that class; pointers reset to ID 0.
  - With no ready entry, no pop and rx0_valid=0.
- Output timing: registered, 1-cycle latency from the pop edge.
  - rx0_valid is high for exactly one cycle per packet.
  - rx0_hdr fields: vc=0, poison=0, hitmiss=0, format=0, clnum=0, resptype=4'hF.
  - mdata[12] (CCIP_UMSG_BITINDEX): 1 for hint, 0 for data.
  - mdata[NUM_UMSG_LOG2-1:0] = ID; all other mdata bits 0.
- An ID with rx0_grant held low stays in SendHint/SendData indefinitely without loss.

Optional Feature:
- ASE_UMSG_STATS_EN defined:
  - stat_hint_cnt and stat_data_cnt increment on each hint/data pop, wrapping at 2**32.
  - Both clear on reset.
- Undefined: both outputs are tied to 0 and the counter registers are not instantiated.

Test Plan:
- Write ID 3, data 512'hA5 repeated, umsg_hint_en[3]=0, rx0_grant=1 -> no hint. One data packet with resptype 4'hF, mdata=16'h0003, rx0_data=A5 pattern, arriving DATA_DELAY+3 cycles after the write. ID 3 returns to Idle, umsg_busy drops.
- Same write with umsg_hint_en[3]=1 -> hint packet (mdata=16'h1003, data=0) at HINT_DELAY+3 cycles, then data packet (mdata=16'h0003) DATA_DELAY+1 cycles after the hint.
- Write ID 5 three times (values 1, 2, 3) while in Waiting -> exactly one data packet carrying 3, then Idle.
- Write ID 0 and ID 7 in consecutive cycles, both hinted, HINT_DELAY=DATA_DELAY, rx0_grant=1 -> hints for 0 then 7 precede any data. Round-robin order is 0 then 7 for data.
- Hold rx0_grant=0 for 200 cycles with ID 2 data_ready -> rx0_valid stays 0. Assert grant -> one packet next cycle.
- Assert rst_n=0 while ID 4 is in SendHint, release -> rx0_valid stays 0 for 1000 cycles. Counters read 0 with ASE_UMSG_STATS_EN.
